// File: rtl/uart_cmd_wrapper.sv
// UART command link responder: assembles two received 8N1 bytes into a 16-bit cmd and sends a response byte.
// Optional feature macro: BYTE_TIMEOUT_EN (abandons a half-received command after TMO_CYC idle cycles).
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 5208,
  parameter int unsigned TMO_CYC  = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int unsigned BW = $clog2(BAUD_DIV) + 1;
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  // Reject configurations where mid-bit sampling or the timeout would be meaningless.
  if (BAUD_DIV < 8 || TMO_CYC < 2) begin : g_param_check
    $error("uart_cmd_wrapper: BAUD_DIV must be >= 8 and TMO_CYC >= 2");
  end

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} byte_state_t;

  rx_state_t   rx_state;
  tx_state_t   tx_state;
  byte_state_t byte_state;

  logic          rx_meta, rx_sync;
  logic [BW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_vld;
  logic [7:0]    hi_byte;

  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;

  // Receiver: two-flop synchronizer, mid-bit sampling of start, 8 data bits and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_vld  <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_RECV;
            rx_cnt   <= BAUD_HALF;
            rx_bit   <= '0;
          end
        end
        RX_RECV: begin
          if (rx_cnt == BW'(1)) begin
            rx_cnt <= BAUD_FULL;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
              if (rx_sync) rx_state <= RX_IDLE;
            end else if (rx_bit == 4'd9) begin
              rx_state <= RX_IDLE;
              if (rx_sync) rx_vld  <= 1'b1;
              else         frm_err <= 1'b1;
            end else begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
            end
          end else begin
            rx_cnt <= rx_cnt - BW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef BYTE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (byte_state == WAIT_LO) && (rx_state == RX_IDLE) && (tmo_cnt == TW'(TMO_CYC - 1));

  // Idle time in WAIT_LO; held at zero while a byte is being received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (byte_state != WAIT_LO || rx_vld || rx_state != RX_IDLE)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  // Byte assembler: high byte is held aside so cmd only changes on a complete pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_state <= WAIT_HI;
      hi_byte    <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (frm_err) begin
        byte_state <= WAIT_HI;
      end else if (rx_vld) begin
        case (byte_state)
          WAIT_HI: begin
            hi_byte    <= rx_shift;
            cmd_rdy    <= 1'b0;
            byte_state <= WAIT_LO;
          end
          WAIT_LO: begin
            cmd        <= {hi_byte, rx_shift};
            cmd_rdy    <= 1'b1;
            byte_state <= WAIT_HI;
          end
          default: byte_state <= WAIT_HI;
        endcase
      end else if (tmo_hit) begin
        byte_state <= WAIT_HI;
      end
    end
  end

  // Transmitter: start bit driven directly, then {stop, data} shifted out LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp && !resp_sent) begin
            tx_shift <= {1'b1, resp};
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= BAUD_FULL;
            tx_bit   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt == BW'(1)) begin
            tx_cnt <= BAUD_FULL;
            if (tx_bit == 4'd9) begin
              tx_state  <= TX_IDLE;
              TX        <= 1'b1;
              tx_busy   <= 1'b0;
              resp_sent <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 4'd1;
              TX       <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - BW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed testbench for uart_cmd_wrapper (BAUD_DIV=16, TMO_CYC=2000).
module tb_uart_cmd_wrapper;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  int total = 0;
  int bad = 0;
  int frm_cnt = 0;
  bit seen_5566 = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(BD), .TMO_CYC(2000)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  always @(negedge clk) begin
    if (frm_err === 1'b1) frm_cnt++;
    if (cmd_rdy === 1'b1 && cmd === 16'h5566) seen_5566 = 1'b1;
  end

  // Host-side byte; a bad stop bit is held low past its sample point, then released.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk); RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    if (stop) repeat (BD) @(negedge clk);
    else      repeat (BD / 2 + 4) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic clear_rdy();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (TX !== 1'b1)       begin bad++; $display("FAIL reset_tx got=%b exp=1", TX); end
    total++; if (cmd !== 16'h0000)  begin bad++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
    total++; if (cmd_rdy !== 1'b0)  begin bad++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
    total++; if (resp_sent !== 1'b0) begin bad++; $display("FAIL reset_resp_sent got=%b exp=0", resp_sent); end
    total++; if (tx_busy !== 1'b0)  begin bad++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL reset_frm_err got=%b exp=0", frm_err); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_rx();
    send_byte(8'h20, 1'b1);
    send_byte(8'h22, 1'b1);
    total++; if (cmd !== 16'h2022) begin bad++; $display("FAIL cmd_2022 got=%h exp=2022", cmd); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL cmd_rdy_set got=%b exp=1", cmd_rdy); end
    repeat (30) @(negedge clk);
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL cmd_rdy_hold got=%b exp=1", cmd_rdy); end
    clear_rdy();
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL cmd_rdy_clr got=%b exp=0", cmd_rdy); end
    total++; if (cmd !== 16'h2022) begin bad++; $display("FAIL cmd_after_clr got=%h exp=2022", cmd); end
  endtask

  // Sends r; with inject, retries send_resp mid-frame and on the resp_sent cycle.
  task automatic run_tx(input logic [7:0] r, input bit inject);
    logic [9:0] exp_frame;
    int sent_at;
    exp_frame = {1'b1, r, 1'b0};
    sent_at = -1;
    @(negedge clk); resp = r; send_resp = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) send_resp = 1'b0;
      if (inject && c == 50) begin resp = 8'h00; send_resp = 1'b1; end
      if (inject && c == 51) send_resp = 1'b0;
      if (c % 16 == 8 && c <= 160) begin
        total++;
        if (TX !== exp_frame[c / 16]) begin
          bad++; $display("FAIL tx_bit%0d got=%b exp=%b", c / 16, TX, exp_frame[c / 16]);
        end
      end
      if (c == 40) begin
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_mid got=%b exp=1", tx_busy); end
      end
      if (sent_at > 0 && c == sent_at + 1) begin
        send_resp = 1'b0;
        total++;
        if (resp_sent !== 1'b0 || tx_busy !== 1'b0) begin
          bad++; $display("FAIL tx_after_sent resp_sent=%b tx_busy=%b exp=0/0", resp_sent, tx_busy);
        end
      end
      if (sent_at < 0 && resp_sent === 1'b1) begin
        sent_at = c;
        total++;
        if (tx_busy !== 1'b0 || TX !== 1'b1) begin
          bad++; $display("FAIL tx_at_sent tx_busy=%b TX=%b exp=0/1", tx_busy, TX);
        end
        if (inject) send_resp = 1'b1;
      end
    end
    total++;
    if (sent_at - 1 != 160) begin bad++; $display("FAIL resp_sent_cycle got=%0d exp=160", sent_at - 1); end
    total++;
    if (tx_busy !== 1'b0 || TX !== 1'b1) begin
      bad++; $display("FAIL tx_idle_end tx_busy=%b TX=%b exp=0/1", tx_busy, TX);
    end
  endtask

  task automatic test_tx();
    run_tx(8'hA5, 1'b0);
  endtask

  task automatic test_tx_ignore();
    run_tx(8'h3C, 1'b1);
  endtask

  task automatic test_frm_err();
    int f0;
    f0 = frm_cnt;
    send_byte(8'hAB, 1'b1);
    send_byte(8'h41, 1'b0);
    total++; if (frm_cnt - f0 != 1) begin bad++; $display("FAIL frm_err_count got=%0d exp=1", frm_cnt - f0); end
    total++; if (cmd !== 16'h2022) begin bad++; $display("FAIL cmd_kept_on_err got=%h exp=2022", cmd); end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    total++; if (cmd !== 16'h1234) begin bad++; $display("FAIL cmd_1234 got=%h exp=1234", cmd); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL cmd_rdy_1234 got=%b exp=1", cmd_rdy); end
    total++; if (frm_cnt - f0 != 1) begin bad++; $display("FAIL frm_err_extra got=%0d exp=1", frm_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h56, 1'b1);
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL rdy_cleared_by_hi got=%b exp=0", cmd_rdy); end
    total++; if (cmd !== 16'h1234) begin bad++; $display("FAIL cmd_held_hi got=%h exp=1234", cmd); end
    send_byte(8'h78, 1'b1);
    total++; if (cmd !== 16'h5678) begin bad++; $display("FAIL cmd_5678 got=%h exp=5678", cmd); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL cmd_rdy_5678 got=%b exp=1", cmd_rdy); end
    clear_rdy();
  endtask

  task automatic test_glitch();
    int f0;
    f0 = frm_cnt;
    @(negedge clk); RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (frm_cnt != f0) begin bad++; $display("FAIL glitch_frm_err got=%0d exp=%0d", frm_cnt, f0); end
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL glitch_rdy got=%b exp=0", cmd_rdy); end
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    total++; if (cmd !== 16'h9ABC) begin bad++; $display("FAIL cmd_9abc got=%h exp=9abc", cmd); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL cmd_rdy_9abc got=%b exp=1", cmd_rdy); end
    clear_rdy();
  endtask

  task automatic test_timeout();
    send_byte(8'h55, 1'b1);
    repeat (2500) @(negedge clk);
    send_byte(8'h66, 1'b1);
`ifdef BYTE_TIMEOUT_EN
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL tmo_hi_only got=%b exp=0", cmd_rdy); end
    send_byte(8'h77, 1'b1);
    total++; if (cmd !== 16'h6677) begin bad++; $display("FAIL tmo_cmd got=%h exp=6677", cmd); end
    total++; if (seen_5566) begin bad++; $display("FAIL tmo_stale got=5566 exp=none"); end
`else
    total++; if (cmd !== 16'h5566) begin bad++; $display("FAIL notmo_cmd got=%h exp=5566", cmd); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL notmo_rdy got=%b exp=1", cmd_rdy); end
    send_byte(8'h77, 1'b1);
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL notmo_next_hi got=%b exp=0", cmd_rdy); end
`endif
  endtask

  initial begin
    test_reset();
    test_cmd_rx();
    test_tx();
    test_frm_err();
    test_back_to_back();
    test_glitch();
    test_tx_ignore();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
